// File: rtl/bus_trace_capture.sv
// bus_trace_capture
// Passive recorder for the 6502 external bus. It registers PHI2, shadows
// A/D/RnW/SYNC while PHI2 is high, and on each PHI2 falling edge (a cycle
// event) it may push one 26-bit record into an internal FIFO. The FIFO is
// drained through a valid/ready read port. An armed capture FSM limits
// each capture to CAP_LEN records; dropped records still count.
//
// Optional feature, macro BUS_TRACE_TRIGGER_EN:
//   defined   - ARMED waits for an opcode fetch (SYNC=1) at TRIG_ADDR
//   undefined - the first cycle event after ARM triggers; TRIG_ADDR unused
//
// Ports:
//   CLK, RES            sampling clock, synchronous active-high reset
//   PHI2, A, D, RnW,    core bus signals, sampled on CLK
//   SYNC
//   ARM, CLEAR          one-CLK pulses: start capture / flush FIFO + OVERFLOW
//   TRIG_ADDR           trigger address (feature only)
//   RD_VALID, RD_READY  read handshake; pop when both high
//   RD_DATA             {SYNC, RnW, A[15:0], D[7:0]} of the FIFO head
//   LEVEL               FIFO occupancy
//   STATE               0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
//   OVERFLOW            sticky, a record was dropped on a full FIFO
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for ARM after reset
// ARMED   | waiting for the trigger cycle event
// CAPTURE | recording one entry per cycle event until CAP_LEN reached
// DONE    | capture complete, FIFO contents kept; ARM re-arms

module bus_trace_capture #(
    parameter int DEPTH   = 16,
    parameter int CAP_LEN = 64
) (
    input  logic                      CLK,
    input  logic                      RES,
    input  logic                      PHI2,
    input  logic [15:0]               A,
    input  logic [7:0]                D,
    input  logic                      RnW,
    input  logic                      SYNC,
    input  logic                      ARM,
    input  logic                      CLEAR,
    input  logic [15:0]               TRIG_ADDR,
    output logic                      RD_VALID,
    input  logic                      RD_READY,
    output logic [25:0]               RD_DATA,
    output logic [$clog2(DEPTH):0]    LEVEL,
    output logic [1:0]                STATE,
    output logic                      OVERFLOW
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [15:0] CAP_LEN_W = 16'(CAP_LEN);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          phi2_q, phi2_d;
    logic          phi2_prev_q, phi2_prev_d;
    logic [25:0]   shadow_q, shadow_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          ovf_q, ovf_d;
    logic [25:0]   mem_q [DEPTH];

    logic          event_w;
    logic          trig_w;
    logic          push_req;
    logic          push_ok;
    logic          pop_w;
    logic          empty_w;
    logic          full_w;
    logic [15:0]   cnt_inc;

    // Event fires in the CLK after phi2_q fell; shadow is stable by then
    // and holds the last sample taken with PHI2 high.
    assign event_w = phi2_prev_q & ~phi2_q;
    assign cnt_inc = cnt_q + 16'd1;

`ifdef BUS_TRACE_TRIGGER_EN
    assign trig_w = shadow_q[25] && (shadow_q[23:8] == TRIG_ADDR);
`else
    logic unused_trig_w;
    assign unused_trig_w = ^TRIG_ADDR;
    assign trig_w        = 1'b1;
`endif

    always_comb begin
        phi2_d      = PHI2;
        phi2_prev_d = phi2_q;
        shadow_d    = shadow_q;
        if (phi2_q) begin
            shadow_d = {SYNC, RnW, A, D};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        push_req = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ARM) begin
                    state_d = S_ARMED;
                    cnt_d   = '0;
                end
            end
            S_ARMED: begin
                // The triggering cycle itself is record 1.
                if (event_w && trig_w) begin
                    push_req = 1'b1;
                    cnt_d    = 16'd1;
                    state_d  = (CAP_LEN_W == 16'd1) ? S_DONE : S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (event_w) begin
                    push_req = 1'b1;
                    cnt_d    = cnt_inc;
                    if (cnt_inc == CAP_LEN_W) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (ARM) begin
                    state_d = S_ARMED;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign empty_w = (wr_ptr_q == rd_ptr_q);
    assign full_w  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // CLEAR overrides pops; a push coinciding with CLEAR is always kept
    // so the FIFO ends holding just that record.
    always_comb begin
        pop_w    = ~empty_w & RD_READY & ~CLEAR;
        push_ok  = push_req & (CLEAR | ~full_w | pop_w);
        wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
        rd_ptr_d = CLEAR ? wr_ptr_q : rd_ptr_q + (AW+1)'(pop_w);
        ovf_d    = CLEAR ? 1'b0 : (ovf_q | (push_req & ~push_ok));
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            phi2_q      <= 1'b0;
            phi2_prev_q <= 1'b0;
            shadow_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phi2_q      <= phi2_d;
            phi2_prev_q <= phi2_prev_d;
            shadow_q    <= shadow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ovf_q       <= ovf_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RES && push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= shadow_q;
        end
    end

    assign RD_VALID = ~empty_w;
    assign RD_DATA  = empty_w ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign LEVEL    = wr_ptr_q - rd_ptr_q;
    assign STATE    = state_q;
    assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_bus_trace_capture.sv
module tb_bus_trace_capture;

    localparam int DEPTH   = 16;
    localparam int CAP_LEN = 20;
    localparam int LW      = $clog2(DEPTH) + 1;

    localparam int M_IDLE = 0, M_ARMED = 1, M_CAP = 2, M_DONE = 3;

    logic          CLK = 1'b0;
    logic          RES, PHI2, RnW, SYNC, ARM, CLEAR, RD_READY;
    logic [15:0]   A, TRIG_ADDR;
    logic [7:0]    D;
    logic          RD_VALID, OVERFLOW;
    logic [25:0]   RD_DATA;
    logic [LW-1:0] LEVEL;
    logic [1:0]    STATE;

    bus_trace_capture #(.DEPTH(DEPTH), .CAP_LEN(CAP_LEN)) dut (
        .CLK(CLK), .RES(RES), .PHI2(PHI2), .A(A), .D(D), .RnW(RnW),
        .SYNC(SYNC), .ARM(ARM), .CLEAR(CLEAR), .TRIG_ADDR(TRIG_ADDR),
        .RD_VALID(RD_VALID), .RD_READY(RD_READY), .RD_DATA(RD_DATA),
        .LEVEL(LEVEL), .STATE(STATE), .OVERFLOW(OVERFLOW)
    );

    always #5 CLK = ~CLK;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [25:0] exp_q[$];
    int          mstate   = M_IDLE;
    int          mcnt     = 0;
    bit          movf     = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: capture rules expressed on whole bus cycles.
    function automatic bit model_trigger(input logic [25:0] rec);
`ifdef BUS_TRACE_TRIGGER_EN
        return rec[25] && (rec[23:8] == TRIG_ADDR);
`else
        return (rec == rec);
`endif
    endfunction

    function automatic void model_event(input logic [25:0] rec, input bit pop_now);
        if (mstate == M_ARMED && model_trigger(rec)) begin
            mstate = M_CAP;
            mcnt   = 0;
        end
        if (mstate == M_CAP) begin
            mcnt++;
            if (exp_q.size() < DEPTH || pop_now) exp_q.push_back(rec);
            else movf = 1'b1;
            if (mcnt == CAP_LEN) mstate = M_DONE;
        end
    endfunction

    function automatic void model_arm();
        if (mstate == M_IDLE || mstate == M_DONE) begin
            mstate = M_ARMED;
            mcnt   = 0;
        end
    endfunction

    function automatic void model_clear();
        exp_q.delete();
        movf = 1'b0;
    endfunction

    // Scoreboard monitor: samples the handshake mid-low-phase.
    initial begin
        logic [25:0] e;
        forever begin
            @(negedge CLK);
            #2;
            if (RD_VALID && RD_READY) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pop: got 0x%0h, expected no entry", RD_DATA);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", RD_DATA, e);
                end
            end
        end
    end

    // mode: 0 ready low, 1 random ready (forced high once per cycle), 2 ready high
    // special: 0 none, 1 pop on the push edge, 2 CLEAR on the push edge
    task automatic bus_cycle(input logic [15:0] a, input logic [7:0] d, input logic rnw,
                             input logic sync, input int mode, input int special);
        logic [25:0] rec;
        rec = {sync, rnw, a, d};
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge CLK);
            if (k == 0) begin
                A = a; D = d; RnW = rnw; SYNC = sync; PHI2 = 1'b0;
            end
            if (k == 1) PHI2 = 1'b1;
            if (k == 3) PHI2 = 1'b0;
            RD_READY = (mode == 2) || (mode == 1 && (k == 1 || $urandom_range(0, 1) == 1));
            if (k == 4) begin
                if (special == 1) RD_READY = 1'b1;
                if (special == 2) begin
                    RD_READY = 1'b0;
                    CLEAR    = 1'b1;
                    model_clear();
                end
                model_event(rec, special == 1);
            end
        end
        @(negedge CLK);
        RD_READY = 1'b0;
        CLEAR    = 1'b0;
        check("state", STATE, mstate);
        check("level", LEVEL, exp_q.size());
        check("overflow", OVERFLOW, movf);
    endtask

    task automatic rand_cycle(input int mode, input int special);
        bus_cycle(16'($urandom_range(0, 65535)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), mode, special);
    endtask

    task automatic pulse_arm();
        ARM = 1'b1;
        model_arm();
        @(negedge CLK);
        ARM = 1'b0;
    endtask

    task automatic pulse_clear();
        CLEAR = 1'b1;
        model_clear();
        @(negedge CLK);
        CLEAR = 1'b0;
    endtask

    task automatic drain();
        int i;
        i = 0;
        RD_READY = 1'b1;
        while (LEVEL != 0 && i < 64) begin
            @(negedge CLK);
            i++;
        end
        RD_READY = 1'b0;
        check("drain_level", LEVEL, 0);
        check("drain_scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RES = 1'b1; PHI2 = 1'b0; A = '0; D = '0; RnW = 1'b1; SYNC = 1'b0;
        ARM = 1'b0; CLEAR = 1'b0; RD_READY = 1'b0; TRIG_ADDR = 16'h8003;
        repeat (3) @(negedge CLK);
        RES = 1'b0;
        check("reset_state", STATE, 0);
        check("reset_level", LEVEL, 0);
        check("reset_valid", RD_VALID, 0);
        check("reset_data", RD_DATA, 0);
        check("reset_overflow", OVERFLOW, 0);

        // Bus activity while IDLE is not recorded.
        rand_cycle(1, 0);
        rand_cycle(1, 0);

        // Reset-vector fetch becomes record 1, then random capture to DONE.
        pulse_arm();
        bus_cycle(16'hFFFC, 8'h00, 1'b1, 1'b0, 0, 0);
        bus_cycle(16'hFFFD, 8'h80, 1'b1, 1'b0, 0, 0);
        check("first_record", RD_DATA, {1'b0, 1'b1, 16'hFFFC, 8'h00});
        for (int i = 0; i < 3; i++) rand_cycle(1, 0);
        pulse_arm();
        for (int i = 0; i < 20; i++) rand_cycle(1, 0);
        check("capture_done", STATE, 3);
        drain();

        // Overflow: 20 records into 16 entries with nobody reading.
        pulse_clear();
        pulse_arm();
        for (int i = 0; i < CAP_LEN; i++) rand_cycle(0, 0);
        check("ovf_level_full", LEVEL, 16);
        check("ovf_set", OVERFLOW, 1);
        drain();
        check("ovf_sticky_after_drain", OVERFLOW, 1);
        pulse_clear();
        check("ovf_cleared", OVERFLOW, 0);

        // Full FIFO with a pop on the push edge.
        pulse_arm();
        for (int i = 0; i < DEPTH; i++) rand_cycle(0, 0);
        rand_cycle(0, 1);
        check("full_pop_push_level", LEVEL, 16);
        check("full_pop_push_ovf", OVERFLOW, 0);
        drain();
        for (int i = 0; i < CAP_LEN - DEPTH - 1; i++) rand_cycle(1, 0);
        check("full_pop_push_done", STATE, 3);

        // DONE with LEVEL=3, then CLEAR and ARM together.
        pulse_clear();
        pulse_arm();
        for (int i = 0; i < CAP_LEN; i++) rand_cycle(0, 0);
        RD_READY = 1'b1;
        repeat (13) @(negedge CLK);
        RD_READY = 1'b0;
        check("done_level3", LEVEL, 3);
        CLEAR = 1'b1;
        ARM   = 1'b1;
        model_clear();
        model_arm();
        @(negedge CLK);
        CLEAR = 1'b0;
        ARM   = 1'b0;
        check("clear_arm_level", LEVEL, 0);
        check("clear_arm_state", STATE, 1);
        check("clear_arm_ovf", OVERFLOW, 0);
        // Full run from a zeroed counter, with a CLEAR landing on a push.
        for (int i = 0; i < CAP_LEN + 4; i++) rand_cycle(1, (i == 5) ? 2 : 0);
        drain();

        // Reset in the middle of a capture.
        pulse_arm();
        for (int i = 0; i < 5; i++) rand_cycle(0, 0);
        check("pre_reset_level", LEVEL, 5);
        check("pre_reset_state", STATE, 2);
        RES = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RES = 1'b0;
        model_clear();
        mstate = M_IDLE;
        mcnt   = 0;
        check("midcap_reset_state", STATE, 0);
        check("midcap_reset_level", LEVEL, 0);
        check("midcap_reset_valid", RD_VALID, 0);
        check("midcap_reset_ovf", OVERFLOW, 0);
        rand_cycle(1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
